reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 101 ++++++++++
 tb/tb_reg_file_2r1w.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with sequenced post-reset initialisation and registered, bypassed reads.
// Optional: define RF_ZERO_REG_EN to hard-wire entry 0 to zero.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   init_cnt, cnt_next;
  logic                ready_next;
  logic [DATA_W-1:0]   rd1_next, rd2_next;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   regs [DEPTH];

  // Control state, counter and read registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      ready      <= 1'b0;
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      state      <= state_next;
      init_cnt   <= cnt_next;
      ready      <= ready_next;
      read_data1 <= rd1_next;
      read_data2 <= rd2_next;
    end
  end

  // The array itself is never cleared; the INIT sweep overwrites every entry.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = init_cnt;
    ready_next = ready;
    wr_en      = 1'b0;
    wr_addr    = write_reg;
    wr_data    = write_data;
    rd1_next   = '0;
    rd2_next   = '0;
    case (state)
      INIT: begin
        wr_en    = 1'b1;
        wr_addr  = init_cnt;
        wr_data  = DATA_W'(init_cnt);
        cnt_next = init_cnt + ADDR_W'(1);
        if (init_cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = RUN;
          ready_next = 1'b1;
        end
      end
      RUN: begin
`ifdef RF_ZERO_REG_EN
        wr_en = reg_write && (write_reg != '0);
`else
        wr_en = reg_write;
`endif
        // Same-edge write forwards the new value to each port independently.
        if (reg_write && (write_reg == read_reg1)) rd1_next = write_data;
        else                                       rd1_next = regs[read_reg1];
        if (reg_write && (write_reg == read_reg2)) rd2_next = write_data;
        else                                       rd2_next = regs[read_reg2];
`ifdef RF_ZERO_REG_EN
        if (read_reg1 == '0) rd1_next = '0;
        if (read_reg2 == '0) rd2_next = '0;
`endif
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w: default 32x32 instance plus a 16-bit x 8-entry instance.
module tb_reg_file_2r1w;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;
  logic        ready;

  logic        reset_s;
  logic [2:0]  read_reg1_s, read_reg2_s, write_reg_s;
  logic [15:0] write_data_s;
  logic        reg_write_s;
  logic [15:0] read_data1_s, read_data2_s;
  logic        ready_s;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_2r1w dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2), .ready(ready)
  );

  reg_file_2r1w #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .reset(reset_s),
    .read_reg1(read_reg1_s), .read_reg2(read_reg2_s),
    .write_reg(write_reg_s), .write_data(write_data_s), .reg_write(reg_write_s),
    .read_data1(read_data1_s), .read_data2(read_data2_s), .ready(ready_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_zero;

  initial begin
    reset = 1'b1; read_reg1 = '0; read_reg2 = '0; write_reg = '0;
    write_data = '0; reg_write = 1'b0;
    reset_s = 1'b1; read_reg1_s = '0; read_reg2_s = '0; write_reg_s = '0;
    write_data_s = '0; reg_write_s = 1'b0;

    repeat (3) step();
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rd1", read_data1, 32'd0);
    check("reset_rd2", read_data2, 32'd0);

    // Release reset with a write attempt in flight during INIT.
    reset = 1'b0;
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h1234;
    read_reg1 = 5'd9; read_reg2 = 5'd31;
    for (int i = 1; i <= 32; i++) begin
      step();
      check("init_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
      check("init_rd1_zero", read_data1, 32'd0);
      check("init_rd2_zero", read_data2, 32'd0);
    end

    reg_write = 1'b0; read_reg1 = 5'd7; read_reg2 = 5'd31;
    step();
    check("run_rd7", read_data1, 32'd7);
    check("run_rd31", read_data2, 32'd31);
    read_reg1 = 5'd9;
    step();
    check("init_write_ignored", read_data1, 32'd9);

    // Bypass on port 1, plain read on port 2.
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    read_reg1 = 5'd5; read_reg2 = 5'd6;
    step();
    check("bypass_rd1", read_data1, 32'hDEADBEEF);
    check("nobypass_rd2", read_data2, 32'd6);
    reg_write = 1'b0; read_reg2 = 5'd5;
    step();
    check("stored_rd1", read_data1, 32'hDEADBEEF);
    check("stored_rd2", read_data2, 32'hDEADBEEF);

    // Entry 0 behaviour depends on the build option.
`ifdef RF_ZERO_REG_EN
    exp_zero = 32'd0;
`else
    exp_zero = 32'h0000FFFF;
`endif
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h0000FFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    step();
    check("zero_bypass_rd1", read_data1, exp_zero);
    check("zero_bypass_rd2", read_data2, exp_zero);
    reg_write = 1'b0;
    step();
    check("zero_stored_rd1", read_data1, exp_zero);
    check("zero_stored_rd2", read_data2, exp_zero);
    check("run_ready_held", {31'b0, ready}, 32'd1);

    // Reset in the middle of a fresh INIT sweep (init_cnt == 10).
    reset = 1'b1;
    step();
    check("rst2_ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    repeat (10) step();
    check("mid_init_ready", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    step();
    check("rst3_ready", {31'b0, ready}, 32'd0);
    check("rst3_rd1", read_data1, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check("reinit_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(31 - a);
      step();
      check("sweep_rd1", read_data1, 32'(a));
      check("sweep_rd2", read_data2, 32'(31 - a));
    end

    // Narrow instance: 8 entries, 16-bit data.
    reset_s = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("s_init_ready", {31'b0, ready_s}, (i == 8) ? 32'd1 : 32'd0);
    end
    read_reg1_s = 3'd7; read_reg2_s = 3'd2;
    step();
    check("s_rd7", {16'b0, read_data1_s}, 32'h0007);
    check("s_rd2", {16'b0, read_data2_s}, 32'h0002);
    reg_write_s = 1'b1; write_reg_s = 3'd3; write_data_s = 16'hA5A5;
    read_reg1_s = 3'd3; read_reg2_s = 3'd3;
    step();
    check("s_b2b_1_rd1", {16'b0, read_data1_s}, 32'hA5A5);
    check("s_b2b_1_rd2", {16'b0, read_data2_s}, 32'hA5A5);
    write_data_s = 16'h5A5A;
    step();
    check("s_b2b_2_rd1", {16'b0, read_data1_s}, 32'h5A5A);
    check("s_b2b_2_rd2", {16'b0, read_data2_s}, 32'h5A5A);
    reg_write_s = 1'b0;
    step();
    check("s_stored_rd1", {16'b0, read_data1_s}, 32'h5A5A);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
